// File: rtl/axis_ram_writer_ring_if.sv
// Bundle for axis_ram_writer_ring: AXI3 write channels (AW/W/B) plus the AXI-Stream sample input.
interface axis_ram_writer_ring_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic                bvalid;
    logic                bready;

    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;

    // The writer drives AW/W, acknowledges B and accepts the stream.
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready,
        input  tdata, tvalid,
        output tready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready,
        output tdata, tvalid,
        input  tready
    );
endinterface

// File: rtl/axis_ram_writer_ring.sv
// AXI-Stream to AXI3 ring-buffer writer: FWFT FIFO feeding fixed-length INCR bursts.
// Optional macro AXIS_RAM_WRITER_DROP_EN: drop words on a full FIFO instead of backpressuring.
module axis_ram_writer_ring #(
    parameter int AXI_ID_WIDTH    = 6,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int BURST_LEN       = 16,
    parameter int ADDR_WIDTH      = 20,
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 64
) (
    input  logic                          aclk_i,
    input  logic                          aresetn_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     cfg_base_i,
    input  logic                          cfg_enable_i,
    output logic [ADDR_WIDTH-1:0]         sts_addr_o,
    output logic [CNT_WIDTH-1:0]          sts_total_o,
    output logic [31:0]                   sts_bursts_o,
    output logic [$clog2(FIFO_DEPTH):0]   sts_fifo_level_o,
`ifdef AXIS_RAM_WRITER_DROP_EN
    output logic [31:0]                   sts_dropped_o,
    output logic                          sts_overflow_o,
`endif
    axis_ram_writer_ring_if.master        bus
);

    localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OUT_W      = 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                    state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;
    logic [PTR_W:0]            level_q, level_d;
    logic                      readyEn_q;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [CNT_WIDTH-1:0]      total_q, total_d;
    logic [31:0]               bursts_q, bursts_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
`ifdef AXIS_RAM_WRITER_DROP_EN
    logic [31:0]               dropped_q, dropped_d;
    logic                      overflow_q, overflow_d;
    logic                      dropEvt;
`endif

    logic fifoFull;
    logic wrEn;
    logic rdEn;
    logic awFire;
    logic lastFire;
    logic isLastBeat;
    logic startBurst;

    assign fifoFull   = (level_q == (PTR_W+1)'(FIFO_DEPTH));
    // readyEn_q keeps tready low while reset is asserted and rises on the first clock after.
    assign wrEn       = bus.tvalid & readyEn_q & ~fifoFull;
    assign rdEn       = (state_q == DATA) & bus.wready;
    assign awFire     = (state_q == ADDR) & bus.awready;
    assign isLastBeat = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign lastFire   = rdEn & isLastBeat;
    assign startBurst = cfg_enable_i
                      & (level_q >= (PTR_W+1)'(BURST_LEN))
                      & (outstanding_q < OUT_W'(MAX_OUTSTANDING));
`ifdef AXIS_RAM_WRITER_DROP_EN
    assign dropEvt    = bus.tvalid & readyEn_q & fifoFull;
`endif

    always_ff @(posedge aclk_i) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= bus.tdata;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (startBurst) state_d = ADDR;
            ADDR:    if (bus.awready) state_d = DATA;
            DATA:    if (lastFire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A burst only starts with BURST_LEN words buffered, so wvalid never waits on the FIFO.
    always_comb begin
        bus.awvalid = (state_q == ADDR);
        bus.awid    = id_q;
        bus.awaddr  = cfg_base_i + (AXI_ADDR_WIDTH'(addr_q) << BYTE_SHIFT);
        bus.awlen   = 4'(BURST_LEN - 1);
        bus.awsize  = 3'(BYTE_SHIFT);
        bus.awburst = 2'b01;
        bus.awcache = 4'b0011;
        bus.wvalid  = (state_q == DATA);
        bus.wid     = id_q;
        bus.wdata   = mem_q[rdPtr_q];
        bus.wstrb   = '1;
        bus.wlast   = (state_q == DATA) & isLastBeat;
        bus.bready  = 1'b1;
`ifdef AXIS_RAM_WRITER_DROP_EN
        bus.tready  = readyEn_q;
`else
        bus.tready  = readyEn_q & ~fifoFull;
`endif
    end

    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        level_d       = level_q + (PTR_W+1)'(wrEn) - (PTR_W+1)'(rdEn);
        addr_d        = addr_q;
        total_d       = total_q;
        beat_d        = beat_q;
        id_d          = id_q;
        outstanding_d = outstanding_q;
        bursts_d      = bursts_q + 32'(bus.bvalid);
        if (wrEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (rdEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            total_d = total_q + CNT_WIDTH'(1);
            beat_d  = lastFire ? '0 : beat_q + BEAT_W'(1);
        end
        if (lastFire) begin
            id_d = id_q + AXI_ID_WIDTH'(1);
        end
        // An AW handshake and a B response in the same cycle cancel out.
        if (awFire && !bus.bvalid) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!awFire && bus.bvalid && outstanding_q != '0) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

`ifdef AXIS_RAM_WRITER_DROP_EN
    always_comb begin
        dropped_d  = dropped_q;
        overflow_d = overflow_q | dropEvt;
        if (dropEvt && dropped_q != '1) begin
            dropped_d = dropped_q + 32'd1;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    assign sts_dropped_o  = dropped_q;
    assign sts_overflow_o = overflow_q;
`endif

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            readyEn_q     <= 1'b0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
            addr_q        <= '0;
            total_q       <= '0;
            bursts_q      <= '0;
            beat_q        <= '0;
            id_q          <= '0;
            outstanding_q <= '0;
        end else begin
            readyEn_q     <= 1'b1;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            level_q       <= level_d;
            addr_q        <= addr_d;
            total_q       <= total_d;
            bursts_q      <= bursts_d;
            beat_q        <= beat_d;
            id_q          <= id_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign sts_addr_o       = addr_q;
    assign sts_total_o      = total_q;
    assign sts_bursts_o     = bursts_q;
    assign sts_fifo_level_o = level_q;

endmodule

// File: tb/tb_axis_ram_writer_ring.sv
// Directed bench for axis_ram_writer_ring with BURST_LEN=8, a 32-beat ring and two outstanding bursts.
module tb_axis_ram_writer_ring;

    localparam int          ID_W   = 6;
    localparam int          AXI_AW = 32;
    localparam int          DW     = 64;
    localparam int          BL     = 8;
    localparam int          RING_W = 5;
    localparam int          FD     = 32;
    localparam int          MAXO   = 2;
    localparam int          CW     = 64;
    localparam logic [31:0] BASE   = 32'h1000_0000;

    logic                  aclk      = 1'b0;
    logic                  aresetn   = 1'b0;
    logic [AXI_AW-1:0]     cfgBase   = BASE;
    logic                  cfgEnable = 1'b0;
    logic [RING_W-1:0]     stsAddr;
    logic [CW-1:0]         stsTotal;
    logic [31:0]           stsBursts;
    logic [$clog2(FD):0]   stsLevel;
`ifdef AXIS_RAM_WRITER_DROP_EN
    logic [31:0]           stsDropped;
    logic                  stsOverflow;
`endif

    axis_ram_writer_ring_if #(.ID_W(ID_W), .ADDR_W(AXI_AW), .DATA_W(DW)) busIf ();

    axis_ram_writer_ring #(
        .AXI_ID_WIDTH(ID_W), .AXI_ADDR_WIDTH(AXI_AW), .AXI_DATA_WIDTH(DW),
        .BURST_LEN(BL), .ADDR_WIDTH(RING_W), .FIFO_DEPTH(FD),
        .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
    ) dut (
        .aclk_i           (aclk),
        .aresetn_i        (aresetn),
        .cfg_base_i       (cfgBase),
        .cfg_enable_i     (cfgEnable),
        .sts_addr_o       (stsAddr),
        .sts_total_o      (stsTotal),
        .sts_bursts_o     (stsBursts),
        .sts_fifo_level_o (stsLevel),
`ifdef AXIS_RAM_WRITER_DROP_EN
        .sts_dropped_o    (stsDropped),
        .sts_overflow_o   (stsOverflow),
`endif
        .bus              (busIf)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int srcIdx   = 0;
    int srcLimit = 0;
    int bManual  = 0;
    bit bAuto    = 1'b1;
    bit wrToggle = 1'b0;

    logic [31:0]     awAddrQ[$];
    logic [ID_W-1:0] awIdQ[$];
    logic [DW-1:0]   wDataQ[$];
    logic            wLastQ[$];

    // Handshakes are logged on the falling edge, where both sides are stable.
    always @(negedge aclk) begin
        if (aresetn && busIf.awvalid && busIf.awready) begin
            awAddrQ.push_back(busIf.awaddr);
            awIdQ.push_back(busIf.awid);
        end
        if (aresetn && busIf.wvalid && busIf.wready) begin
            wDataQ.push_back(busIf.wdata);
            wLastQ.push_back(busIf.wlast);
        end
    end

    // Stream source: word n carries the value n; words are offered up to srcLimit.
    initial begin
        bit fire;
        busIf.tvalid = 1'b0;
        busIf.tdata  = '0;
        forever begin
            @(negedge aclk);
            fire = busIf.tvalid && busIf.tready;
            @(posedge aclk);
            #1;
            if (fire) srcIdx++;
            busIf.tvalid = (srcIdx < srcLimit);
            busIf.tdata  = DW'(srcIdx);
        end
    end

    initial begin
        busIf.wready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            busIf.wready = wrToggle ? ~busIf.wready : 1'b1;
        end
    end

    // B responder: one response per observed wlast while bAuto is set, plus bManual extra pulses.
    initial begin
        int autoCnt;
        int bIssued;
        bit lastSeen;
        autoCnt = 0;
        bIssued = 0;
        busIf.bvalid = 1'b0;
        forever begin
            @(negedge aclk);
            lastSeen = bAuto && busIf.wvalid && busIf.wready && busIf.wlast;
            @(posedge aclk);
            #1;
            if (lastSeen) autoCnt++;
            if (autoCnt + bManual > bIssued) begin
                busIf.bvalid = 1'b1;
                bIssued++;
            end else begin
                busIf.bvalid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int limit, input int waitCycles);
        srcLimit = limit;
        repeat (waitCycles) @(negedge aclk);
    endtask

    initial begin
        logic [31:0] ringOfs [4];
        int orderErr;
        int lastErr;
        int readyLow;
        ringOfs[0] = 32'h00; ringOfs[1] = 32'h40; ringOfs[2] = 32'h80; ringOfs[3] = 32'hC0;
        busIf.awready = 1'b0;

        repeat (3) @(negedge aclk);
        checkOutput("rst_awvalid", 64'(busIf.awvalid), 0);
        checkOutput("rst_wvalid", 64'(busIf.wvalid), 0);
        checkOutput("rst_tready", 64'(busIf.tready), 0);
        checkOutput("rst_sts_addr", 64'(stsAddr), 0);
        checkOutput("rst_sts_total", stsTotal, 0);
        checkOutput("rst_sts_bursts", 64'(stsBursts), 0);
        checkOutput("rst_level", 64'(stsLevel), 0);

        @(posedge aclk);
        #1;
        aresetn       = 1'b1;
        cfgEnable     = 1'b1;
        busIf.awready = 1'b1;

        // One word short of a burst: nothing may be issued.
        applyStimulus(7, 20);
        checkOutput("no_aw_7_words", 64'(awAddrQ.size()), 0);
        checkOutput("level_7", 64'(stsLevel), 7);
        applyStimulus(8, 0);
        for (int i = 0; i < 50 && awAddrQ.size() == 0; i++) @(negedge aclk);
        checkOutput("aw_on_8th_word", 64'(awAddrQ.size()), 1);
        checkOutput("awlen", 64'(busIf.awlen), 7);
        checkOutput("awsize", 64'(busIf.awsize), 3);
        checkOutput("awburst", 64'(busIf.awburst), 1);
        checkOutput("awcache", 64'(busIf.awcache), 3);
        checkOutput("bready", 64'(busIf.bready), 1);

        // 48 words: six bursts, wrapping the 32-beat ring once.
        applyStimulus(48, 0);
        for (int i = 0; i < 1500 && !(stsTotal == 48 && stsBursts == 6); i++) @(negedge aclk);
        checkOutput("wrap_total", stsTotal, 48);
        checkOutput("wrap_bursts", 64'(stsBursts), 6);
        checkOutput("wrap_aw_count", 64'(awAddrQ.size()), 6);
        checkOutput("wrap_sts_addr", 64'(stsAddr), 16);
        checkOutput("wrap_level", 64'(stsLevel), 0);

        // Withhold B: only two more bursts may be issued.
        bAuto = 1'b0;
        applyStimulus(80, 200);
        checkOutput("outst_aw_count", 64'(awAddrQ.size()), 8);
        checkOutput("outst_bursts", 64'(stsBursts), 6);
        checkOutput("outst_total", stsTotal, 64);
        checkOutput("outst_level", 64'(stsLevel), 16);
        bManual = 1;
        for (int i = 0; i < 100 && awAddrQ.size() < 9; i++) @(negedge aclk);
        checkOutput("one_b_aw_count", 64'(awAddrQ.size()), 9);
        checkOutput("one_b_bursts", 64'(stsBursts), 7);
        repeat (60) @(negedge aclk);
        checkOutput("still_blocked", 64'(awAddrQ.size()), 9);
        bAuto   = 1'b1;
        bManual = 3;
        for (int i = 0; i < 500 && !(stsTotal == 80 && stsBursts == 10); i++) @(negedge aclk);
        checkOutput("drain_total", stsTotal, 80);
        checkOutput("drain_bursts", 64'(stsBursts), 10);
        checkOutput("drain_sts_addr", 64'(stsAddr), 16);

        // wready toggling every cycle.
        wrToggle = 1'b1;
        applyStimulus(96, 0);
        for (int i = 0; i < 1000 && !(stsTotal == 96 && stsBursts == 12); i++) @(negedge aclk);
        checkOutput("toggle_total", stsTotal, 96);
        checkOutput("toggle_aw_count", 64'(awAddrQ.size()), 12);
        wrToggle = 1'b0;

        // Drop enable during beat 5 of the next burst.
        applyStimulus(120, 0);
        for (int i = 0; i < 500 && stsTotal != 101; i++) @(negedge aclk);
        cfgEnable = 1'b0;
        repeat (100) @(negedge aclk);
        checkOutput("disable_total", stsTotal, 104);
        checkOutput("disable_aw_count", 64'(awAddrQ.size()), 13);
        checkOutput("disable_sts_addr", 64'(stsAddr), 8);
        checkOutput("disable_level", 64'(stsLevel), 16);
        cfgEnable = 1'b1;
        for (int i = 0; i < 1000 && !(stsTotal == 120 && stsBursts == 15); i++) @(negedge aclk);
        checkOutput("resume_total", stsTotal, 120);
        checkOutput("resume_aw_count", 64'(awAddrQ.size()), 15);
        checkOutput("resume_sts_addr", 64'(stsAddr), 24);

        // Address and id of every burst: ring offsets repeat every four bursts.
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("aw_addr_%0d", i), (i < awAddrQ.size()) ? 64'(awAddrQ[i]) : 64'hDEAD, 64'(BASE + ringOfs[i % 4]));
            checkOutput($sformatf("aw_id_%0d", i), (i < awIdQ.size()) ? 64'(awIdQ[i]) : 64'hDEAD, 64'(i));
        end

        checkOutput("w_beat_count", 64'(wDataQ.size()), 120);
        orderErr = 0;
        lastErr  = 0;
        for (int i = 0; i < wDataQ.size(); i++) begin
            if (wDataQ[i] !== DW'(i)) orderErr++;
            if (wLastQ[i] !== ((i % BL) == BL - 1)) lastErr++;
        end
        checkOutput("w_data_order_errors", 64'(orderErr), 0);
        checkOutput("w_last_errors", 64'(lastErr), 0);

`ifdef AXIS_RAM_WRITER_DROP_EN
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        checkOutput("rst_dropped", 64'(stsDropped), 0);
        checkOutput("rst_overflow", 64'(stsOverflow), 0);
        @(posedge aclk);
        #1;
        busIf.awready = 1'b0;
        aresetn       = 1'b1;
        @(negedge aclk);
        applyStimulus(srcIdx + FD + 10, 0);
        readyLow = 0;
        repeat (80) begin
            @(negedge aclk);
            if (!busIf.tready) readyLow++;
        end
        checkOutput("drop_count", 64'(stsDropped), 10);
        checkOutput("drop_overflow", 64'(stsOverflow), 1);
        checkOutput("drop_tready_low_cycles", 64'(readyLow), 0);
        checkOutput("drop_level", 64'(stsLevel), FD);
`else
        // Stall AW: the FIFO fills to depth and backpressures the stream.
        busIf.awready = 1'b0;
        readyLow = 0;
        applyStimulus(srcIdx + 40, 80);
        checkOutput("bp_level", 64'(stsLevel), FD);
        checkOutput("bp_tready", 64'(busIf.tready), 0);
        checkOutput("bp_accepted", 64'(srcIdx), 120 + FD);
        checkOutput("bp_awvalid_held", 64'(busIf.awvalid), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_ram_writer_ring.md
Name: axis_ram_writer_ring

Overview:
- Parametrised AXI3 write-master successor to the fixed 16-beat DMA writer.
- Buffers an AXI-Stream sample stream in an internal FIFO and writes it to DDR as fixed-length INCR bursts into a power-of-two ring buffer.
- Adds configurable burst length, outstanding-response tracking, an enable gate and a burst-completion counter.
- Sits between the ADC sample pipeline and the PS HP port.

Parameters:
- AXI_ID_WIDTH, 6, AXI ID width.
- AXI_ADDR_WIDTH, 32, AXI address and cfg_base width.
- AXI_DATA_WIDTH, 64, AXI/AXIS data width in bits; legal values 32 or 64.
- BURST_LEN, 16, beats per burst; power of two, 1..16.
- ADDR_WIDTH, 20, ring index width in beats; ring holds 2^ADDR_WIDTH beats; must be >= log2(BURST_LEN).
- FIFO_DEPTH, 512, FIFO depth in words; power of two, >= 2*BURST_LEN.
- MAX_OUTSTANDING, 4, maximum bursts awaiting a B response; 1..15.
- CNT_WIDTH, 64, width of the total beat counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_base  in  AXI_ADDR_WIDTH  ring base byte address; aligned to the ring size in bytes.
- cfg_enable  in  1  allows new bursts to start.
- sts_addr  out  ADDR_WIDTH  next ring beat index to be written.
- sts_total  out  CNT_WIDTH  total beats accepted on W.
- sts_bursts  out  32  B responses received.
- sts_fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- m_axi_aw*  out/in  AXI3  awid, awaddr, awlen[3:0], awsize, awburst, awcache, awvalid, awready.
- m_axi_w*  out/in  AXI3  wid, wdata, wstrb, wlast, wvalid, wready.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready; tied 1.
- s_axis_tdata  in  AXI_DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.

Behaviour:
- Reset: asynchronous, active-low on aresetn. All registers clear, FIFO empties, FSM goes to IDLE. awvalid=0, wvalid=0, sts_*=0, s_axis_tready=0 while in reset. A reset asserted mid-burst abandons the burst; the system resets the interconnect together with this block.
- FIFO: synchronous, inferred, first-word-fall-through. Writes when tvalid & tready; tready = ~full. Read on W handshake.
- FSM states and transitions:
  - IDLE -> ADDR when cfg_enable & level >= BURST_LEN & outstanding < MAX_OUTSTANDING.
  - ADDR: awvalid=1. awaddr = cfg_base + (sts_addr << log2(AXI_DATA_WIDTH/8)). awlen = BURST_LEN-1, awsize = log2(bytes), awburst = INCR, awcache = 4'b0011, awid = wid = burst id.
  - ADDR -> DATA on awready. Outstanding count increments at this handshake.
  - DATA: wvalid=1 (data is guaranteed present). Each wready beat: sts_addr+1 modulo 2^ADDR_WIDTH, sts_total+1, beat counter+1. wlast asserts on beat BURST_LEN-1.
  - DATA -> IDLE after the wlast handshake. Burst id increments (wraps modulo 2^AXI_ID_WIDTH).
  - Minimum 1 idle cycle between bursts.
- Wrap: bursts are index-aligned, so no burst crosses the ring end or a 4 KB boundary. sts_addr returns to 0 after index 2^ADDR_WIDTH-1.
- Outstanding count: increments on AW handshake, decrements on bvalid. Simultaneous events give a net 0 change. sts_bursts increments on each bvalid. bresp is ignored.
- Dropping cfg_enable mid-burst: the current burst completes; no new burst starts. The FIFO keeps filling until full.
- sts_fifo_level is registered and updates one cycle after the FIFO write/read.

Optional Feature:
- Macro AXIS_RAM_WRITER_DROP_EN.
- Defined:
  - s_axis_tready is held at 1 outside reset.
  - A word arriving while the FIFO is full is discarded.
  - Adds port sts_dropped (out, 32): dropped-word count, saturating.
  - Adds port sts_overflow (out, 1): sticky flag, cleared only by reset.
- Undefined: backpressure via tready = ~full; these ports are absent.

Test Plan:
- BURST_LEN=16: stream 64 words 0..63 with awready/wready always 1 -> 4 bursts at cfg_base+0x0, 0x80, 0x100, 0x180; wlast on every 16th beat; awid 0..3; sts_total=64.
- ADDR_WIDTH=5, BURST_LEN=8: stream 48 words -> 6 bursts; addresses wrap to cfg_base after index 31; sts_addr=16.
- MAX_OUTSTANDING=2 with bvalid withheld -> exactly 2 AW handshakes. Pulse bvalid once -> a third burst starts; sts_bursts=1.
- Feed 15 words with BURST_LEN=16 -> no AW issued. 16th word -> awvalid asserts. Toggling wready 50% -> data order preserved.
- Deassert cfg_enable during beat 5 -> that burst finishes at 16 beats, no further AW. Reassert -> bursting resumes at the next index.
- With AXIS_RAM_WRITER_DROP_EN defined and awready=0: push FIFO_DEPTH+10 words -> sts_dropped=10, sts_overflow=1, tready stays 1.
